// File: rtl/serial_regfile_engine.sv
// ---------------------------------------------------------------------------
// serial_regfile_engine
//
// Purpose:
//   Bit-serial register file with its own access sequencer. A single
//   valid/ready handshake either reads two registers (rs1/rs2) into parallel
//   output words, or writes one parallel word into rd. Storage moves LANE bits
//   per cycle, so an op takes N = XLEN/LANE shift cycles plus the done cycle.
//
// Parameters:
//   XLEN     - data word width
//   LANE     - bits moved per shift cycle, must divide XLEN
//   NUM_REGS - number of registers
//   SEL_W    - register-select width, derived from NUM_REGS
//
// Ports:
//   i_clk       clock
//   i_rst_n     synchronous active-low reset, clears storage and aborts ops
//   i_op_valid  op request
//   o_op_ready  engine idle, op accepted on edge where valid & ready
//   i_op_write  1 = write rd, 0 = read rs1/rs2
//   i_rs1_sel   read select 1
//   i_rs2_sel   read select 2
//   i_rd_sel    write select
//   i_wr_data   write word
//   o_rs1_data  read result 1, stable from done until the next read accept
//   o_rs2_data  read result 2, stable from done until the next read accept
//   o_done      one-cycle completion pulse
//
// Configuration macro:
//   RF_X0_ZERO_EN - when defined, register 0 is hard-wired to zero: it reads 0
//                   and writes to it are dropped (op timing is unchanged).
// ---------------------------------------------------------------------------
module serial_regfile_engine #(
    parameter int XLEN     = 32,
    parameter int LANE     = 2,
    parameter int NUM_REGS = 16,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic             i_op_write,
    input  logic [SEL_W-1:0] i_rs1_sel,
    input  logic [SEL_W-1:0] i_rs2_sel,
    input  logic [SEL_W-1:0] i_rd_sel,
    input  logic [XLEN-1:0]  i_wr_data,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic             o_done
);

    localparam int N     = XLEN / LANE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

`ifdef RF_X0_ZERO_EN
    localparam int FIRST_REG = 1;
`else
    localparam int FIRST_REG = 0;
`endif

    generate
        if (LANE < 1 || (XLEN % LANE) != 0) begin : g_lane_check
            $error("serial_regfile_engine: LANE (%0d) must divide XLEN (%0d)", LANE, XLEN);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    // Shift a lane into the top of a word while dropping its bottom lane.
    // Built from a wide concatenation so LANE == XLEN needs no special case.
    function automatic logic [XLEN-1:0] shiftIn(input logic [LANE-1:0] lane,
                                                input logic [XLEN-1:0] word);
        logic [XLEN+LANE-1:0] wide;
        wide = {lane, word} >> LANE;
        return wide[XLEN-1:0];
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_regs [NUM_REGS];
    logic [XLEN-1:0]    r_buf;
    logic [SEL_W-1:0]   r_rs1_sel;
    logic [SEL_W-1:0]   r_rs2_sel;
    logic [SEL_W-1:0]   r_rd_sel;
    logic [XLEN-1:0]    r_rs1_data;
    logic [XLEN-1:0]    r_rs2_data;
    logic               r_done;

    logic               w_op_ready;
    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_rs1_ok;
    logic               w_rs2_ok;
    logic               w_rd_ok;
    logic [LANE-1:0]    w_rs1_lane;
    logic [LANE-1:0]    w_rs2_lane;

    // Selects only go out of range when NUM_REGS is not a power of two, so
    // the range check exists only in that case.
    generate
        if (NUM_REGS == (1 << SEL_W)) begin : g_full_map
            assign w_rs1_ok = 1'b1;
            assign w_rs2_ok = 1'b1;
            assign w_rd_ok  = 1'b1;
        end else begin : g_part_map
            localparam logic [SEL_W:0] REGS_LIM = (SEL_W + 1)'(NUM_REGS);
            assign w_rs1_ok = ({1'b0, r_rs1_sel} < REGS_LIM);
            assign w_rs2_ok = ({1'b0, r_rs2_sel} < REGS_LIM);
            assign w_rd_ok  = ({1'b0, r_rd_sel}  < REGS_LIM);
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode. The last shift cycle returns to IDLE so
    // the done cycle is also an idle cycle that can accept the next op.
    always_comb begin
        w_next_state = r_state;
        w_op_ready   = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_op_ready = 1'b1;
                if (i_op_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = i_op_write ? S_WRITE : S_READ;
                end
            end
            S_READ, S_WRITE: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Lanes currently at the bottom of the selected source registers;
    // out-of-range selects read as zero.
    always_comb begin
        w_rs1_lane = '0;
        w_rs2_lane = '0;
        if (w_rs1_ok) begin
            w_rs1_lane = r_regs[r_rs1_sel][LANE-1:0];
        end
        if (w_rs2_ok) begin
            w_rs2_lane = r_regs[r_rs2_sel][LANE-1:0];
        end
    end

    // Datapath. Every register rotates during any op so all of them realign
    // after N cycles; the write target instead takes lanes from the buffer.
    // With the zero-register option, register 0 is never updated after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_buf      <= '0;
            r_rs1_sel  <= '0;
            r_rs2_sel  <= '0;
            r_rd_sel   <= '0;
            r_cnt      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_rs1_sel <= i_rs1_sel;
                r_rs2_sel <= i_rs2_sel;
                r_rd_sel  <= i_rd_sel;
                r_buf     <= i_wr_data;
                r_cnt     <= '0;
            end
            if (w_shift) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                r_buf <= r_buf >> LANE;
                for (int i = FIRST_REG; i < NUM_REGS; i++) begin
                    if (r_state == S_WRITE && w_rd_ok && r_rd_sel == SEL_W'(i)) begin
                        r_regs[i] <= shiftIn(r_buf[LANE-1:0], r_regs[i]);
                    end else begin
                        r_regs[i] <= shiftIn(r_regs[i][LANE-1:0], r_regs[i]);
                    end
                end
                if (r_state == S_READ) begin
                    r_rs1_data <= shiftIn(w_rs1_lane, r_rs1_data);
                    r_rs2_data <= shiftIn(w_rs2_lane, r_rs2_data);
                end
            end
        end
    end

    assign o_op_ready = w_op_ready;
    assign o_rs1_data = r_rs1_data;
    assign o_rs2_data = r_rs2_data;
    assign o_done     = r_done;

endmodule

// File: tb/tb_serial_regfile_engine.sv
// ---------------------------------------------------------------------------
// tb_serial_regfile_engine
//
// Directed bench for serial_regfile_engine. Main instance uses XLEN=32,
// LANE=2, NUM_REGS=16; four extra instances (LANE=1,4,8,32) share one set of
// stimulus for the lane sweep. Expected values are hand-computed constants.
// Follows RF_X0_ZERO_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_serial_regfile_engine;

    logic        clk = 1'b0;
    logic        rstN;
    logic        opValid;
    logic        opReady;
    logic        opWrite;
    logic [3:0]  rs1Sel;
    logic [3:0]  rs2Sel;
    logic [3:0]  rdSel;
    logic [31:0] wrData;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        done;

    logic        swValid;
    logic        swWrite;
    logic [3:0]  swSel;
    logic [31:0] swData;
    logic [3:0]  swReady;
    logic [3:0]  swDone;
    logic [31:0] swRs1 [4];
    logic [31:0] swRs2 [4];

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    serial_regfile_engine #(.XLEN(32), .LANE(2), .NUM_REGS(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_op_valid (opValid),
        .o_op_ready (opReady),
        .i_op_write (opWrite),
        .i_rs1_sel  (rs1Sel),
        .i_rs2_sel  (rs2Sel),
        .i_rd_sel   (rdSel),
        .i_wr_data  (wrData),
        .o_rs1_data (rs1Data),
        .o_rs2_data (rs2Data),
        .o_done     (done)
    );

    // Lane sweep instances: LANE = 1, 4, 8, 32.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sweep
            localparam int SW_LANE = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
            serial_regfile_engine #(.XLEN(32), .LANE(SW_LANE), .NUM_REGS(16)) swDut (
                .i_clk      (clk),
                .i_rst_n    (rstN),
                .i_op_valid (swValid),
                .o_op_ready (swReady[g]),
                .i_op_write (swWrite),
                .i_rs1_sel  (swSel),
                .i_rs2_sel  (swSel),
                .i_rd_sel   (swSel),
                .i_wr_data  (swData),
                .o_rs1_data (swRs1[g]),
                .o_rs2_data (swRs2[g]),
                .o_done     (swDone[g])
            );
        end
    endgenerate

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one op on the main instance and returns cycles from accept to
    // done. Called and returns at posedge+1.
    task automatic applyStimulus(input bit write, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic [3:0] rd, input logic [31:0] data,
                                 output int latency);
        int guard = 0;
        while (!opReady && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ready_before_op", opReady, 1);
        opWrite = write;
        rs1Sel  = s1;
        rs2Sel  = s2;
        rdSel   = rd;
        wrData  = data;
        opValid = 1'b1;
        @(posedge clk); #1;
        opValid = 1'b0;
        checkOutput("busy_not_ready", opReady, 0);
        latency = 1;
        @(posedge clk); #1;
        while (!done && latency < 60) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    initial begin
        int lat;
        int accepts;
        int lastAccept;
        bit prevReady;
        bit prevDone;
        bit readSeen;
        int swLat [4];
        int swExp [4];
        swExp = '{32, 8, 4, 1};

        rstN    = 1'b0;
        opValid = 1'b0;
        opWrite = 1'b0;
        rs1Sel  = '0;
        rs2Sel  = '0;
        rdSel   = '0;
        wrData  = '0;
        swValid = 1'b0;
        swWrite = 1'b0;
        swSel   = '0;
        swData  = '0;

        // 1: reset state, then read of empty registers
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", opReady, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rs1", rs1Data, 0);
        checkOutput("rst_rs2", rs2Data, 0);
        rstN = 1'b1;
        applyStimulus(1'b0, 4'd5, 4'd6, 4'd0, 32'h0, lat);
        checkOutput("t1_latency", lat, 16);
        checkOutput("t1_rs1", rs1Data, 0);
        checkOutput("t1_rs2", rs2Data, 0);
        @(posedge clk); #1;
        checkOutput("t1_done_drops", done, 0);
        checkOutput("t1_ready_idle", opReady, 1);

        // 2: write r3 then read it back on both ports; others stay zero
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd3, 32'hDEADBEEF, lat);
        checkOutput("t2_wr_latency", lat, 16);
        applyStimulus(1'b0, 4'd2, 4'd4, 4'd0, 32'h0, lat);
        checkOutput("t2_r2", rs1Data, 0);
        checkOutput("t2_r4", rs2Data, 0);
        applyStimulus(1'b0, 4'd15, 4'd0, 4'd0, 32'h0, lat);
        checkOutput("t2_r15", rs1Data, 0);
        checkOutput("t2_r0", rs2Data, 0);
        applyStimulus(1'b0, 4'd3, 4'd3, 4'd0, 32'h0, lat);
        checkOutput("t2_rd_latency", lat, 16);
        checkOutput("t2_rs1_r3", rs1Data, 32'hDEADBEEF);
        checkOutput("t2_rs2_r3", rs2Data, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t2_rs1_stable", rs1Data, 32'hDEADBEEF);

        // 3: write r0; a write must leave the read outputs untouched
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 32'h12345678, lat);
        checkOutput("t3_wr_latency", lat, 16);
        checkOutput("t3_rs1_kept", rs1Data, 32'hDEADBEEF);
        checkOutput("t3_rs2_kept", rs2Data, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'd0, 4'd3, 4'd0, 32'h0, lat);
`ifdef RF_X0_ZERO_EN
        checkOutput("t3_r0", rs1Data, 32'h00000000);
`else
        checkOutput("t3_r0", rs1Data, 32'h12345678);
`endif
        checkOutput("t3_r3", rs2Data, 32'hDEADBEEF);

        // 4: op_valid held high for 40 cycles, alternating write/read/write
        opWrite = 1'b1;
        rdSel   = 4'd7;
        wrData  = 32'h0BADF00D;
        opValid = 1'b1;
        accepts    = 0;
        lastAccept = 0;
        readSeen   = 1'b0;
        prevReady  = opReady;
        prevDone   = done;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (prevReady) begin
                if (accepts > 0) begin
                    checkOutput("t4_accept_in_done", prevDone, 1);
                    checkOutput("t4_interval", cyc - lastAccept, 17);
                end
                accepts++;
                lastAccept = cyc;
                if (accepts == 1) begin
                    opWrite = 1'b0;
                    rs1Sel  = 4'd7;
                    rs2Sel  = 4'd3;
                end else if (accepts == 2) begin
                    opWrite = 1'b1;
                    rdSel   = 4'd7;
                    wrData  = 32'h11223344;
                end
            end
            if (done && accepts == 2 && !readSeen) begin
                readSeen = 1'b1;
                checkOutput("t4_read_r7", rs1Data, 32'h0BADF00D);
                checkOutput("t4_read_r3", rs2Data, 32'hDEADBEEF);
            end
            prevReady = opReady;
            prevDone  = done;
        end
        opValid = 1'b0;
        checkOutput("t4_accepts", accepts, 3);
        checkOutput("t4_read_seen", readSeen, 1);
        applyStimulus(1'b0, 4'd7, 4'd7, 4'd0, 32'h0, lat);
        checkOutput("t4_final_r7", rs1Data, 32'h11223344);

        // 5: reset during shift cycle 7 of a write aborts it and clears storage
        opWrite = 1'b1;
        rdSel   = 4'd3;
        wrData  = 32'hCAFEF00D;
        opValid = 1'b1;
        @(posedge clk); #1;
        opValid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rstN = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_ready", opReady, 1);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_rs1_cleared", rs1Data, 0);
        rstN = 1'b1;
        applyStimulus(1'b0, 4'd3, 4'd7, 4'd0, 32'h0, lat);
        checkOutput("t5_r3", rs1Data, 0);
        checkOutput("t5_r7", rs2Data, 0);

        // 6: lane sweep, write r15 then read it back on every instance
        checkOutput("t6_ready", swReady, 4'hF);
        swWrite = 1'b1;
        swSel   = 4'd15;
        swData  = 32'hA5A55A5A;
        swValid = 1'b1;
        @(posedge clk); #1;
        swValid = 1'b0;
        swLat = '{0, 0, 0, 0};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                if (swDone[j] && swLat[j] == 0) swLat[j] = k;
            end
        end
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("t6_wr_latency_%0d", j), swLat[j], swExp[j]);
        end
        swWrite = 1'b0;
        swValid = 1'b1;
        @(posedge clk); #1;
        swValid = 1'b0;
        swLat = '{0, 0, 0, 0};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                if (swDone[j] && swLat[j] == 0) swLat[j] = k;
            end
        end
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("t6_rd_latency_%0d", j), swLat[j], swExp[j]);
            checkOutput($sformatf("t6_rs1_%0d", j), swRs1[j], 32'hA5A55A5A);
            checkOutput($sformatf("t6_rs2_%0d", j), swRs2[j], 32'hA5A55A5A);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
